// File: rtl/uv_stream_rx.sv
// Sequence receiver: buffers a valid/ready word stream in a small FIFO and flags breaks in an incrementing sequence.
// Optional embedded safety assertions are enabled with UV_STREAM_RX_PROPS_EN.
module uv_stream_rx #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             seq_err,
  output logic [WIDTH-1:0] rx_count
);

  localparam int NENT = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [NENT];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  first_q, err_q;
  logic [WIDTH-1:0]      exp_q, rx_cnt_q;
  logic                  push, pop;

  assign in_ready  = (count_q < DEPTH);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign seq_err   = err_q;
  assign rx_count  = rx_cnt_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NENT; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      first_q  <= 1'b1;
      exp_q    <= '0;
      err_q    <= 1'b0;
      rx_cnt_q <= '0;
    end else begin
      count_q <= count_d;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        rx_cnt_q        <= rx_cnt_q + 1'b1;
        // checker always resyncs to the word just seen
        exp_q           <= in_data + 1'b1;
        first_q         <= 1'b0;
        if (!first_q && (in_data != exp_q)) err_q <= 1'b1;
      end
    end
  end

`ifdef UV_STREAM_RX_PROPS_EN
  logic [DEPTH_LOG2-1:0] ptr_diff;
  assign ptr_diff = wr_ptr_q - rd_ptr_q;

  always @* begin
    if (rst) begin
      prop_cnt: assert (count_q <= DEPTH);
      prop_rdy: assert (in_ready == (count_q != DEPTH));
      prop_vld: assert (out_valid == (count_q != '0));
      prop_ptr: assert (ptr_diff == count_q[DEPTH_LOG2-1:0]);
    end
  end
`endif

endmodule
